uart_rx_core: RTL and testbench

Synthesizable UART receiver for the APB UART: consumes the serial `rx` line driven by the peripheral's external pin (or by the testbench UART interface) and delivers parallel characters upstream to the RX FIFO/APB register stage through a valid/ready handshake. Frame format (data bits, parity, stop bits) and bit period are run-time configurable from the register block. Parity, framing and overrun errors are flagged per character.

---
 rtl/uart_rx_pkg.sv | 22 ++
 rtl/uart_rx_if.sv | 11 +
 rtl/uart_rx_sampler.sv | 64 ++++++
 rtl/uart_rx_core.sv | 155 +++++++++++++++
 tb/tb_uart_rx_core.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and constants for the UART receiver (feature macro UART_RX_MAJORITY_VOTE_EN)
package uart_rx_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } uart_rx_state_e;

    localparam int UART_MIN_CLK_DIV = 4;

    localparam logic [1:0] DATA_BITS_5 = 2'd0;
    localparam logic [1:0] DATA_BITS_6 = 2'd1;
    localparam logic [1:0] DATA_BITS_7 = 2'd2;
    localparam logic [1:0] DATA_BITS_8 = 2'd3;

    function automatic logic [3:0] num_data_bits(input logic [1:0] enc);
        return {2'b00, enc} + 4'd5;
    endfunction
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: character valid/ready handshake between the receiver and its consumer
interface uart_rx_if;
    logic [7:0] data_o;
    logic       parity_err_o;
    logic       frame_err_o;
    logic       valid_o;
    logic       ready_i;

    modport master (output data_o, parity_err_o, frame_err_o, valid_o, input ready_i);
    modport slave  (input data_o, parity_err_o, frame_err_o, valid_o, output ready_i);
endinterface

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: rx synchronizer, bit-period counter and sample strobe (UART_RX_MAJORITY_VOTE_EN selects 2-of-3 voting)
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int CLK_DIV_W = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 i_rx,
    input  logic                 i_start,
    input  logic                 i_active,
    input  logic [CLK_DIV_W-1:0] i_clk_div_live,
    input  logic [CLK_DIV_W-1:0] i_clk_div_held,
    output logic                 o_rx_sync,
    output logic                 o_sample_valid,
    output logic                 o_sample_bit
);
    localparam logic [CLK_DIV_W-1:0] MIN_DIV = CLK_DIV_W'(UART_MIN_CLK_DIV);
    localparam logic [CLK_DIV_W-1:0] ONE     = CLK_DIV_W'(1);

    logic [1:0]           r_sync;
    logic [CLK_DIV_W-1:0] r_cnt;
    logic [CLK_DIV_W-1:0] w_div_live;
    logic [CLK_DIV_W-1:0] w_div_held;
    logic                 w_tick;

    assign w_div_live = (i_clk_div_live < MIN_DIV) ? MIN_DIV : i_clk_div_live;
    assign w_div_held = (i_clk_div_held < MIN_DIV) ? MIN_DIV : i_clk_div_held;
    assign w_tick     = i_active && !i_start && (r_cnt == '0);
    assign o_rx_sync  = r_sync[1];

    // Two-flop synchronizer; half-period load on start, full-period reload at each mid-bit tick
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync <= 2'b11;
            r_cnt  <= '0;
        end else begin
            r_sync <= {r_sync[0], i_rx};
            r_cnt  <= i_start ? (w_div_live >> 1) : w_tick ? (w_div_held - ONE) : (r_cnt != '0) ? (r_cnt - ONE) : r_cnt;
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [1:0] r_hist;
    logic       r_tick_d;

    // Keep the two previous synchronized samples and delay the tick so mid-bit+1 is available
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hist   <= 2'b11;
            r_tick_d <= 1'b0;
        end else begin
            r_hist   <= {r_hist[0], r_sync[1]};
            r_tick_d <= w_tick;
        end
    end

    assign o_sample_valid = r_tick_d;
    assign o_sample_bit   = (r_sync[1] & r_hist[0]) | (r_sync[1] & r_hist[1]) | (r_hist[0] & r_hist[1]);
`else
    assign o_sample_valid = w_tick;
    assign o_sample_bit   = r_sync[1];
`endif
endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: configurable UART receiver with valid/ready output and error flags (option UART_RX_MAJORITY_VOTE_EN)
module uart_rx_core
    import uart_rx_pkg::*;
#(
    parameter int CLK_DIV_W = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [CLK_DIV_W-1:0] clk_div_i,
    input  logic [1:0]           data_bits_i,
    input  logic                 parity_en_i,
    input  logic                 parity_type_i,
    input  logic                 stop2_i,
    input  logic                 rx_i,
    uart_rx_if.master            rx_if,
    output logic                 overrun_o,
    output logic                 busy_o
);
    uart_rx_state_e       r_state, w_state_n;
    logic [CLK_DIV_W-1:0] r_div;
    logic [3:0]           r_nbits;
    logic                 r_par_en, r_par_type, r_stop2;
    logic [3:0]           r_bit_cnt, w_bit_cnt_n;
    logic [7:0]           r_shift, w_shift_n;
    logic                 r_par_err, w_par_err_n;
    logic                 r_frame_err, w_frame_err_n;
    logic                 r_stop_second, w_stop_second_n;
    logic                 r_rx_prev;
    logic [7:0]           r_data;
    logic                 r_valid, r_perr, r_ferr, r_overrun;
    logic                 w_rx_sync, w_sample_valid, w_sample_bit;
    logic                 w_fall, w_start, w_active, w_done, w_accept, w_load;
    logic [7:0]           w_data_aligned;
    logic                 w_par_exp;

    assign w_fall         = r_rx_prev & ~w_rx_sync;
    assign w_start        = (r_state == ST_IDLE) && w_fall;
    assign w_active       = (r_state == ST_START) || (r_state == ST_DATA) || (r_state == ST_PARITY) || (r_state == ST_STOP);
    assign w_data_aligned = r_shift >> (4'd8 - r_nbits);
    assign w_par_exp      = ^w_data_aligned ^ r_par_type;
    assign w_accept       = r_valid & rx_if.ready_i;
    assign w_load         = w_done & (~r_valid | w_accept);

    assign rx_if.data_o       = r_data;
    assign rx_if.parity_err_o = r_perr;
    assign rx_if.frame_err_o  = r_ferr;
    assign rx_if.valid_o      = r_valid;
    assign overrun_o          = r_overrun;
    assign busy_o             = (r_state != ST_IDLE);

    uart_rx_sampler #(.CLK_DIV_W(CLK_DIV_W)) u_sampler (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .i_rx           (rx_i),
        .i_start        (w_start),
        .i_active       (w_active),
        .i_clk_div_live (clk_div_i),
        .i_clk_div_held (r_div),
        .o_rx_sync      (w_rx_sync),
        .o_sample_valid (w_sample_valid),
        .o_sample_bit   (w_sample_bit)
    );

    // Frame sequencing: next state and per-frame datapath updates on each mid-bit sample
    always_comb begin
        w_state_n       = r_state;
        w_bit_cnt_n     = r_bit_cnt;
        w_shift_n       = r_shift;
        w_par_err_n     = r_par_err;
        w_frame_err_n   = r_frame_err;
        w_stop_second_n = r_stop_second;
        w_done          = 1'b0;
        case (r_state)
            ST_IDLE: if (w_fall) begin
                w_state_n       = ST_START;
                w_bit_cnt_n     = 4'd0;
                w_shift_n       = 8'd0;
                w_par_err_n     = 1'b0;
                w_frame_err_n   = 1'b0;
                w_stop_second_n = 1'b0;
            end
            ST_START: if (w_sample_valid) w_state_n = w_sample_bit ? ST_IDLE : ST_DATA;
            ST_DATA: if (w_sample_valid) begin
                w_shift_n   = {w_sample_bit, r_shift[7:1]};
                w_bit_cnt_n = r_bit_cnt + 4'd1;
                if (r_bit_cnt + 4'd1 == r_nbits) w_state_n = r_par_en ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: if (w_sample_valid) begin
                w_par_err_n = (w_sample_bit != w_par_exp);
                w_state_n   = ST_STOP;
            end
            ST_STOP: if (w_sample_valid) begin
                w_frame_err_n = r_frame_err | ~w_sample_bit;
                if (r_stop2 && !r_stop_second) begin
                    w_stop_second_n = 1'b1;
                end else begin
                    w_done    = 1'b1;
                    w_state_n = (r_frame_err | ~w_sample_bit) ? ST_WAIT_HIGH : ST_IDLE;
                end
            end
            ST_WAIT_HIGH: if (w_rx_sync) w_state_n = ST_IDLE;
            default: w_state_n = ST_IDLE;
        endcase
    end

    // State and frame registers; configuration captured when a frame starts
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= ST_IDLE;
            r_bit_cnt     <= 4'd0;
            r_shift       <= 8'd0;
            r_par_err     <= 1'b0;
            r_frame_err   <= 1'b0;
            r_stop_second <= 1'b0;
            r_rx_prev     <= 1'b1;
            r_div         <= '0;
            r_nbits       <= 4'd8;
            r_par_en      <= 1'b0;
            r_par_type    <= 1'b0;
            r_stop2       <= 1'b0;
        end else begin
            r_state       <= w_state_n;
            r_bit_cnt     <= w_bit_cnt_n;
            r_shift       <= w_shift_n;
            r_par_err     <= w_par_err_n;
            r_frame_err   <= w_frame_err_n;
            r_stop_second <= w_stop_second_n;
            r_rx_prev     <= w_rx_sync;
            if (w_start) begin
                r_div      <= clk_div_i;
                r_nbits    <= num_data_bits(data_bits_i);
                r_par_en   <= parity_en_i;
                r_par_type <= parity_type_i;
                r_stop2    <= stop2_i;
            end
        end
    end

    // Output holding register: load when empty or being drained, otherwise flag overrun
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_data    <= 8'd0;
            r_valid   <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_valid   <= w_load | (r_valid & ~w_accept);
            r_data    <= w_load ? w_data_aligned : r_data;
            r_perr    <= w_load ? r_par_err : r_perr;
            r_ferr    <= w_load ? w_frame_err_n : r_ferr;
            r_overrun <= w_done & ~w_load;
        end
    end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed self-checking bench for uart_rx_core
module tb_uart_rx_core;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] clk_div = 32'd868;
    logic [1:0]  data_bits = 2'd3;
    logic        parity_en = 1'b0;
    logic        parity_type = 1'b0;
    logic        stop2 = 1'b0;
    logic        rx = 1'b1;
    logic        overrun;
    logic        busy;
    int          bit_cycles = 868;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          n_acc = 0;
    int          n_ovr = 0;
    logic [7:0]  last_d = 8'h00;
    logic        last_pe = 1'b0;
    logic        last_fe = 1'b0;

    uart_rx_if u_if ();

    uart_rx_core #(.CLK_DIV_W(32)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .clk_div_i     (clk_div),
        .data_bits_i   (data_bits),
        .parity_en_i   (parity_en),
        .parity_type_i (parity_type),
        .stop2_i       (stop2),
        .rx_i          (rx),
        .rx_if         (u_if),
        .overrun_o     (overrun),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (u_if.valid_o && u_if.ready_i) begin
                n_acc   <= n_acc + 1;
                last_d  <= u_if.data_o;
                last_pe <= u_if.parity_err_o;
                last_fe <= u_if.frame_err_o;
            end
            if (overrun) n_ovr <= n_ovr + 1;
        end
    end

    task automatic cfg(input int div, input int cyc, input logic [1:0] db, input logic pe, input logic pt, input logic s2);
        clk_div = div; bit_cycles = cyc; data_bits = db; parity_en = pe; parity_type = pt; stop2 = s2;
    endtask

    task automatic send(input logic [11:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx = bits[i];
            repeat (bit_cycles) @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int nbits);
        rx = 1'b1;
        repeat (nbits * bit_cycles) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++; if (u_if.valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", u_if.valid_o); end
        n_cmp++; if (u_if.data_o !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", u_if.data_o); end
        n_cmp++; if (u_if.parity_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b want 0", u_if.parity_err_o); end
        n_cmp++; if (u_if.frame_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b want 0", u_if.frame_err_o); end
        n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_8n1;
        int a0;
        cfg(868, 868, 2'd3, 1'b0, 1'b0, 1'b0);
        a0 = n_acc;
        send({2'b00, 1'b1, 8'hA5, 1'b0}, 10);
        idle(2);
        n_cmp++; if (n_acc !== a0 + 1) begin n_fail++; $display("FAIL 8n1_count: got %0d want %0d", n_acc, a0 + 1); end
        n_cmp++; if (last_d !== 8'hA5) begin n_fail++; $display("FAIL 8n1_data: got %h want a5", last_d); end
        n_cmp++; if (last_pe !== 1'b0 || last_fe !== 1'b0) begin n_fail++; $display("FAIL 8n1_errs: got pe=%b fe=%b want 0 0", last_pe, last_fe); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL 8n1_busy: got %b want 0", busy); end
    endtask

    task automatic test_parity;
        cfg(32, 32, 2'd3, 1'b1, 1'b1, 1'b0);
        send({1'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, 11);
        idle(2);
        n_cmp++; if (last_d !== 8'h3C) begin n_fail++; $display("FAIL odd_bad_data: got %h want 3c", last_d); end
        n_cmp++; if (last_pe !== 1'b1) begin n_fail++; $display("FAIL odd_bad_perr: got %b want 1", last_pe); end
        send({1'b0, 1'b1, 1'b1, 8'h3C, 1'b0}, 11);
        idle(2);
        n_cmp++; if (last_pe !== 1'b0) begin n_fail++; $display("FAIL odd_good_perr: got %b want 0", last_pe); end
        n_cmp++; if (last_fe !== 1'b0) begin n_fail++; $display("FAIL odd_good_ferr: got %b want 0", last_fe); end
    endtask

    task automatic test_min_div;
        cfg(2, 4, 2'd0, 1'b0, 1'b0, 1'b0);
        send({5'b00000, 1'b1, 5'h13, 1'b0}, 7);
        idle(3);
        n_cmp++; if (last_d !== 8'h13) begin n_fail++; $display("FAIL min_div_5bit_data: got %h want 13", last_d); end
        n_cmp++; if (last_fe !== 1'b0) begin n_fail++; $display("FAIL min_div_ferr: got %b want 0", last_fe); end
    endtask

    task automatic test_frame_err;
        int a0;
        cfg(32, 32, 2'd3, 1'b0, 1'b0, 1'b0);
        a0 = n_acc;
        send({2'b00, 1'b0, 8'h55, 1'b0}, 10);
        repeat (20 * 32) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL break_busy: got %b want 1", busy); end
        n_cmp++; if (n_acc !== a0 + 1) begin n_fail++; $display("FAIL break_count: got %0d want %0d", n_acc, a0 + 1); end
        n_cmp++; if (last_fe !== 1'b1) begin n_fail++; $display("FAIL break_ferr: got %b want 1", last_fe); end
        n_cmp++; if (last_d !== 8'h55) begin n_fail++; $display("FAIL break_data: got %h want 55", last_d); end
        idle(3);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL break_release_busy: got %b want 0", busy); end
        n_cmp++; if (n_acc !== a0 + 1) begin n_fail++; $display("FAIL break_release_count: got %0d want %0d", n_acc, a0 + 1); end
    endtask

    task automatic test_glitch;
        int a0;
        cfg(868, 868, 2'd3, 1'b0, 1'b0, 1'b0);
        a0 = n_acc;
        rx = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        rx = 1'b1;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_start: got %b want 1", busy); end
        repeat (600) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_end: got %b want 0", busy); end
        n_cmp++; if (n_acc !== a0) begin n_fail++; $display("FAIL glitch_count: got %0d want %0d", n_acc, a0); end
    endtask

    task automatic test_overrun;
        int a0;
        int o0;
        cfg(32, 32, 2'd3, 1'b0, 1'b0, 1'b0);
        u_if.ready_i = 1'b0;
        a0 = n_acc;
        o0 = n_ovr;
        send({2'b00, 1'b1, 8'h11, 1'b0}, 10);
        idle(2);
        send({2'b00, 1'b1, 8'h22, 1'b0}, 10);
        idle(2);
        n_cmp++; if (u_if.valid_o !== 1'b1) begin n_fail++; $display("FAIL ovr_valid: got %b want 1", u_if.valid_o); end
        n_cmp++; if (u_if.data_o !== 8'h11) begin n_fail++; $display("FAIL ovr_data: got %h want 11", u_if.data_o); end
        n_cmp++; if (n_ovr !== o0 + 1) begin n_fail++; $display("FAIL ovr_pulses: got %0d want %0d", n_ovr, o0 + 1); end
        n_cmp++; if (n_acc !== a0) begin n_fail++; $display("FAIL ovr_no_accept: got %0d want %0d", n_acc, a0); end
        u_if.ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (u_if.valid_o !== 1'b0) begin n_fail++; $display("FAIL ovr_drain_valid: got %b want 0", u_if.valid_o); end
        n_cmp++; if (last_d !== 8'h11 || n_acc !== a0 + 1) begin n_fail++; $display("FAIL ovr_drain: got %h/%0d want 11/%0d", last_d, n_acc, a0 + 1); end
        cfg(32, 32, 2'd2, 1'b1, 1'b0, 1'b1);
        send({1'b0, 2'b11, 1'b0, 7'h55, 1'b0}, 11);
        idle(2);
        n_cmp++; if (last_d !== 8'h55) begin n_fail++; $display("FAIL 7e2_data: got %h want 55", last_d); end
        n_cmp++; if (last_pe !== 1'b0 || last_fe !== 1'b0) begin n_fail++; $display("FAIL 7e2_errs: got pe=%b fe=%b want 0 0", last_pe, last_fe); end
        n_cmp++; if (n_ovr !== o0 + 1) begin n_fail++; $display("FAIL 7e2_no_overrun: got %0d want %0d", n_ovr, o0 + 1); end
        send({1'b0, 2'b01, 1'b0, 7'h55, 1'b0}, 11);
        idle(3);
        n_cmp++; if (last_fe !== 1'b1 || last_pe !== 1'b0) begin n_fail++; $display("FAIL 7e2_stop2_low: got fe=%b pe=%b want 1 0", last_fe, last_pe); end
    endtask

    task automatic test_reset_mid;
        int a0;
        cfg(32, 32, 2'd3, 1'b0, 1'b0, 1'b0);
        a0 = n_acc;
        send(12'h000, 4);
        rst = 1'b1;
        rx = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        n_cmp++; if (u_if.valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b want 0", u_if.valid_o); end
        idle(10);
        n_cmp++; if (n_acc !== a0) begin n_fail++; $display("FAIL rst_mid_discard: got %0d want %0d", n_acc, a0); end
        send({2'b00, 1'b1, 8'h0F, 1'b0}, 10);
        idle(2);
        n_cmp++; if (n_acc !== a0 + 1 || last_d !== 8'h0F) begin n_fail++; $display("FAIL rst_mid_next: got %0d/%h want %0d/0f", n_acc, last_d, a0 + 1); end
        n_cmp++; if (last_pe !== 1'b0 || last_fe !== 1'b0) begin n_fail++; $display("FAIL rst_mid_next_errs: got pe=%b fe=%b want 0 0", last_pe, last_fe); end
    endtask

    initial begin
        u_if.ready_i = 1'b1;
        test_reset;
        test_8n1;
        test_parity;
        test_min_div;
        test_frame_err;
        test_glitch;
        test_overrun;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
